// File: rtl/ext_chan_initiator.sv
// ext_chan_initiator: requester end of the ext_chan handshake, one transaction at a time for the core.
// Define EXT_CHAN_RETRY_EN to build the backoff/reissue path taken after a responder reports nodata.

`ifndef ADDR_SIZE
`define ADDR_SIZE 8
`endif
`ifndef DATA_SIZE
`define DATA_SIZE 8
`endif
`ifndef RS232_DATA_ADDR
`define RS232_DATA_ADDR 1
`endif

module ext_chan_initiator #(
    parameter int unsigned RETRY_MAX = 15,
    parameter int unsigned BACKOFF   = 8,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clk_oe,
    input  logic                   cmd_read,
    input  logic                   cmd_write,
    input  logic [`ADDR_SIZE-1:0]  cmd_chan,
    input  logic [`DATA_SIZE-1:0]  cmd_wdata,
    output logic                   cmd_busy,
    output logic                   cmd_done,
    output logic [1:0]             cmd_status,
    output logic [`DATA_SIZE-1:0]  cmd_rdata,
    output logic [`ADDR_SIZE-1:0]  ext_chan_no_out,
    output logic [`DATA_SIZE-1:0]  ext_chan_data_out,
    output logic                   ext_chan_r_q,
    output logic                   ext_chan_w_q,
    input  logic [`ADDR_SIZE-1:0]  ext_chan_no_in,
    input  logic [`DATA_SIZE-1:0]  ext_chan_data_in,
    input  logic                   ext_chan_r_dn,
    input  logic                   ext_chan_w_dn,
    input  logic                   ext_chan_nodata_in
);

    // state   | meaning
    // IDLE    | waiting for a command from the core
    // REQ     | request driven, waiting for matching dn / nodata / timeout
    // BACKOFF | request dropped after nodata, idling before reissue
    // DONE    | one-cycle completion pulse, then back to IDLE
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_BACKOFF = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    localparam logic [1:0]  ST_OK      = 2'd0;
    localparam logic [1:0]  ST_NODATA  = 2'd1;
    localparam logic [1:0]  ST_TIMEOUT = 2'd2;
    localparam logic [15:0] TO_LAST    = 16'(TIMEOUT - 1);

    state_t      state;
    state_t      state_nx;
    logic        dir_write;
    logic [15:0] to_cnt;
    logic        start;
    logic        match;
    logic        to_hit;
    logic        retry_ok;

    assign start  = (state == S_IDLE) && (cmd_read || cmd_write);
    // ext_chan_no_out holds the latched channel for the whole REQ/BACKOFF span
    assign match  = (dir_write ? ext_chan_w_dn : ext_chan_r_dn) &&
                    (ext_chan_no_in == ext_chan_no_out);
    assign to_hit = (to_cnt == TO_LAST);

`ifdef EXT_CHAN_RETRY_EN
    localparam logic [3:0] RETRY_CAP = 4'(RETRY_MAX);
    localparam logic [7:0] BO_LAST   = 8'(BACKOFF - 1);

    logic [3:0] retry_cnt;
    logic [7:0] bo_cnt;
    logic       bo_last;

    assign retry_ok = (retry_cnt < RETRY_CAP);
    assign bo_last  = (bo_cnt == BO_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            retry_cnt <= '0;
            bo_cnt    <= '0;
        end else if (clk_oe) begin
            if (start) begin
                retry_cnt <= '0;
            end else if ((state == S_REQ) && !match && ext_chan_nodata_in && retry_ok) begin
                retry_cnt <= retry_cnt + 4'd1;
                bo_cnt    <= '0;
            end else if ((state == S_BACKOFF) && !bo_last) begin
                bo_cnt <= bo_cnt + 8'd1;
            end
        end
    end
`else
    assign retry_ok = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else if (clk_oe) begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (start) state_nx = S_REQ;
            end
            S_REQ: begin
                if (match) begin
                    state_nx = S_DONE;
                end else if (ext_chan_nodata_in) begin
                    state_nx = retry_ok ? S_BACKOFF : S_DONE;
                end else if (to_hit) begin
                    state_nx = S_DONE;
                end
            end
`ifdef EXT_CHAN_RETRY_EN
            S_BACKOFF: begin
                if (bo_last) state_nx = S_REQ;
            end
`endif
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_busy = (state == S_REQ) || (state == S_BACKOFF);
        cmd_done = (state == S_DONE);
    end

    // Request lines drop on the same edge that samples dn/nodata/timeout,
    // so a responder never sees a stale request after it has answered.
    always_ff @(posedge clk) begin
        if (rst) begin
            dir_write         <= 1'b0;
            to_cnt            <= '0;
            cmd_status        <= ST_OK;
            cmd_rdata         <= '0;
            ext_chan_no_out   <= '0;
            ext_chan_data_out <= '0;
            ext_chan_r_q      <= 1'b0;
            ext_chan_w_q      <= 1'b0;
        end else if (clk_oe) begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        dir_write         <= cmd_write;
                        to_cnt            <= '0;
                        cmd_status        <= ST_OK;
                        cmd_rdata         <= '0;
                        ext_chan_no_out   <= cmd_chan;
                        ext_chan_data_out <= cmd_write ? cmd_wdata : '0;
                        ext_chan_w_q      <= cmd_write;
                        ext_chan_r_q      <= !cmd_write;
                    end
                end
                S_REQ: begin
                    if (match) begin
                        ext_chan_r_q      <= 1'b0;
                        ext_chan_w_q      <= 1'b0;
                        if (!dir_write) cmd_rdata <= ext_chan_data_in;
                        cmd_status        <= ST_OK;
                        ext_chan_no_out   <= '0;
                        ext_chan_data_out <= '0;
                    end else if (ext_chan_nodata_in) begin
                        ext_chan_r_q <= 1'b0;
                        ext_chan_w_q <= 1'b0;
                        if (!retry_ok) begin
                            cmd_status        <= ST_NODATA;
                            ext_chan_no_out   <= '0;
                            ext_chan_data_out <= '0;
                        end
                    end else if (to_hit) begin
                        ext_chan_r_q      <= 1'b0;
                        ext_chan_w_q      <= 1'b0;
                        cmd_status        <= ST_TIMEOUT;
                        ext_chan_no_out   <= '0;
                        ext_chan_data_out <= '0;
                    end else begin
                        to_cnt <= to_cnt + 16'd1;
                    end
                end
`ifdef EXT_CHAN_RETRY_EN
                S_BACKOFF: begin
                    if (bo_last) begin
                        ext_chan_r_q <= !dir_write;
                        ext_chan_w_q <= dir_write;
                        to_cnt       <= '0;
                    end
                end
`endif
                default: begin
                end
            endcase
        end
    end

endmodule
